// File: rtl/robo_pkg.sv
// Shared definitions for the wall-following robot controller:
// state encoding, drive-output bundle, output decode and counter sizing.
package robo_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        INIT    = 3'd0,
        SEARCH  = 3'd1,
        ROTATE  = 3'd2,
        FOLLOW  = 3'd3,
        REMOVE  = 3'd4,
        STANDBY = 3'd5
    } state_t;

    typedef struct packed {
        logic avancar;
        logic girar;
        logic remover;
    } drive_t;

    // Width able to hold 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Moore decode of motor/arm drives from the registered state.
    function automatic drive_t decode(input state_t s);
        drive_t d;
        d = '0;
        case (s)
            SEARCH, FOLLOW: d.avancar = 1'b1;
            ROTATE:         d.girar   = 1'b1;
            REMOVE:         d.remover = 1'b1;
            default:        d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/robo_sat_counter.sv
// Saturating up-counter with synchronous clear and load.
// Priority: reset/clr, then load, then inc; holds at all-ones.
module robo_sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count
);

    // Count register; saturates instead of wrapping.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments keep register updates order-independent across always blocks.
        if (reset || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/robo_ctrl_param.sv
// Parametrised wall-following robot controller.
// Moore FSM with follow-side select, bounded rotation (stuck detection)
// and timed barrier removal with a retry limit.
// Optional build macro ROBO_STATS_EN adds the removed_count statistics port.
module robo_ctrl_param
    import robo_pkg::*;
#(
    parameter int ROT_MAX    = 4,
    parameter int REM_CYCLES = 3,
    parameter int RETRY_MAX  = 2,
    parameter int STAT_W     = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               follow_right,
    input  logic               head,
    input  logic               left,
    input  logic               right,
    input  logic               under,
    input  logic               barrier,
    output logic               avancar,
    output logic               girar,
    output logic               remover,
    output logic [STATE_W-1:0] estado
`ifdef ROBO_STATS_EN
    ,
    output logic [STAT_W-1:0]  removed_count
`endif
);

    localparam int ROT_W = cnt_width(ROT_MAX - 1);
    localparam int REM_W = cnt_width(REM_CYCLES - 1);
    localparam int RET_W = cnt_width(RETRY_MAX);

    localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROT_MAX - 1);
    localparam logic [REM_W-1:0] REM_LOAD = REM_W'(REM_CYCLES - 1);
    localparam logic [RET_W-1:0] RET_LIM  = RET_W'(RETRY_MAX);

    state_t             state, state_nxt;
    logic [REM_W-1:0]   rem_cnt, rem_nxt;
    logic [RET_W-1:0]   retry_cnt, retry_nxt;
    logic [ROT_W-1:0]   rot_cnt;
    logic               side;
    drive_t             drv;

    assign side = follow_right ? right : left;

    // Next-state and removal counter updates; under beats barrier beats per-state rules.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_nxt = state;
        rem_nxt   = rem_cnt;
        retry_nxt = retry_cnt;
        if (!(state inside {INIT, SEARCH, ROTATE, FOLLOW, REMOVE})) begin
            // STANDBY is absorbing; unused codes fall into it as well.
            state_nxt = STANDBY;
        end else if (under) begin
            state_nxt = STANDBY;
        end else if (barrier && (state != REMOVE)) begin
            state_nxt = REMOVE;
            rem_nxt   = REM_LOAD;
            retry_nxt = '0;
        end else begin
            case (state)
                INIT: begin
                    if (side)      state_nxt = FOLLOW;
                    else if (head) state_nxt = ROTATE;
                    else           state_nxt = SEARCH;
                end
                SEARCH: begin
                    if (head)      state_nxt = ROTATE;
                    else if (side) state_nxt = FOLLOW;
                end
                FOLLOW: begin
                    if (head)       state_nxt = ROTATE;
                    else if (!side) state_nxt = SEARCH;
                end
                ROTATE: begin
                    if (!head)                  state_nxt = side ? FOLLOW : SEARCH;
                    else if (rot_cnt == ROT_LAST) state_nxt = STANDBY;
                end
                REMOVE: begin
                    if (rem_cnt != '0) begin
                        rem_nxt = rem_cnt - 1'b1;
                    end else if (!barrier) begin
                        state_nxt = side ? FOLLOW : SEARCH;
                    end else if (retry_cnt != RET_LIM) begin
                        rem_nxt   = REM_LOAD;
                        retry_nxt = retry_cnt + 1'b1;
                    end else begin
                        state_nxt = STANDBY;
                    end
                end
                default: state_nxt = STANDBY;
            endcase
        end
    end

    // State and removal counters, synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= INIT;
            rem_cnt   <= '0;
            retry_cnt <= '0;
        end else begin
            state     <= state_nxt;
            rem_cnt   <= rem_nxt;
            retry_cnt <= retry_nxt;
        end
    end

    // Rotation length counter: counts while staying in ROTATE, clears on any exit.
    robo_sat_counter #(.WIDTH(ROT_W)) u_rot_cnt (
        .clock    (clock),
        .reset    (reset),
        .inc      (state == ROTATE),
        .clr      (state_nxt != ROTATE),
        .load     (1'b0),
        .load_val ({ROT_W{1'b0}}),
        .count    (rot_cnt)
    );

`ifdef ROBO_STATS_EN
    logic rem_success;

    // A removal succeeds when the last hold cycle ends with the barrier gone.
    assign rem_success = (state == REMOVE) && !under && (rem_cnt == '0) && !barrier;

    robo_sat_counter #(.WIDTH(STAT_W)) u_stats (
        .clock    (clock),
        .reset    (reset),
        .inc      (rem_success),
        .clr      (1'b0),
        .load     (1'b0),
        .load_val ({STAT_W{1'b0}}),
        .count    (removed_count)
    );
`endif

    // Outputs decoded straight from the registered state (no added latency).
    assign drv     = decode(state);
    assign avancar = drv.avancar;
    assign girar   = drv.girar;
    assign remover = drv.remover;
    assign estado  = state;

endmodule

// File: tb/tb_robo_ctrl_param.sv
// Self-checking bench for robo_ctrl_param (default parameters).
// Expected state/output tuples are queued when stimulus is driven and
// compared one clock later against the DUT.
module tb_robo_ctrl_param;

    localparam logic [2:0] S_INIT = 3'd0, S_SEARCH = 3'd1, S_ROTATE = 3'd2,
                           S_FOLLOW = 3'd3, S_REMOVE = 3'd4, S_STANDBY = 3'd5;

    logic       clock = 1'b0;
    logic       reset, follow_right, head, left, right, under, barrier;
    logic       avancar, girar, remover;
    logic [2:0] estado;
`ifdef ROBO_STATS_EN
    logic [7:0] removed_count;
`endif

    typedef struct packed {
        logic [2:0] st;
        logic       av;
        logic       gi;
        logic       rm;
    } obs_t;

    obs_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    robo_ctrl_param dut (
        .clock         (clock),
        .reset         (reset),
        .follow_right  (follow_right),
        .head          (head),
        .left          (left),
        .right         (right),
        .under         (under),
        .barrier       (barrier),
        .avancar       (avancar),
        .girar         (girar),
        .remover       (remover),
        .estado        (estado)
`ifdef ROBO_STATS_EN
        ,
        .removed_count (removed_count)
`endif
    );

    // Expected drives for a state code, straight from the output table.
    function automatic obs_t expect_of(input logic [2:0] st);
        obs_t o;
        o.st = st;
        o.av = (st == S_SEARCH) || (st == S_FOLLOW);
        o.gi = (st == S_ROTATE);
        o.rm = (st == S_REMOVE);
        return o;
    endfunction

    // Drive one cycle of inputs {follow_right,head,left,right,under,barrier}
    // and queue the state expected after the next edge.
    task automatic apply(input logic [5:0] stim, input logic [2:0] exp_st);
        {follow_right, head, left, right, under, barrier} = stim;
        sb.push_back(expect_of(exp_st));
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {follow_right, head, left, right, under, barrier} = 6'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got, want;
        sb.push_back(expect_of(S_INIT));
        do_reset();
        got = {estado, avancar, girar, remover}; want = sb.pop_front(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL reset: got %b want %b", got, want);
        end
`ifdef ROBO_STATS_EN
        vectors++;
        if (removed_count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_stats: got %0d want 0", removed_count);
        end
`endif
    endtask

    task automatic run_table(input string name, input logic [8:0] tbl[$]);
        obs_t got, want;
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i][8:3], tbl[i][2:0]);
            got = {estado, avancar, girar, remover}; want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL %s[%0d]: got st=%0d av=%b gi=%b rm=%b, want st=%0d av=%b gi=%b rm=%b",
                         name, i, got.st, got.av, got.gi, got.rm, want.st, want.av, want.gi, want.rm);
            end
        end
    endtask

    task automatic check_stats(input string name, input int want_cnt);
`ifdef ROBO_STATS_EN
        vectors++;
        if (removed_count !== want_cnt[7:0]) begin
            miscompares++;
            $display("FAIL %s: removed_count got %0d want %0d", name, removed_count, want_cnt);
        end
`else
        if (want_cnt < 0) $display("negative stats expectation in %s", name);
`endif
    endtask

    task automatic test_follow_left();
        do_reset();
        run_table("follow_left", '{
            {6'b001000, S_FOLLOW}, {6'b001000, S_FOLLOW},
            {6'b000000, S_SEARCH}, {6'b001000, S_FOLLOW}});
    endtask

    task automatic test_follow_right();
        do_reset();
        run_table("follow_right", '{
            {6'b101000, S_SEARCH}, {6'b101000, S_SEARCH},
            {6'b101100, S_FOLLOW}, {6'b100100, S_FOLLOW},
            {6'b101000, S_SEARCH}});
    endtask

    task automatic test_rotate_stuck();
        do_reset();
        run_table("rotate_stuck", '{
            {6'b001000, S_FOLLOW},
            {6'b011000, S_ROTATE}, {6'b011000, S_ROTATE},
            {6'b011000, S_ROTATE}, {6'b011000, S_ROTATE},
            {6'b011000, S_STANDBY},
            {6'b000011, S_STANDBY}, {6'b001000, S_STANDBY}});
    endtask

    task automatic test_rotate_exit();
        do_reset();
        run_table("rotate_exit", '{
            {6'b010000, S_ROTATE}, {6'b010000, S_ROTATE},
            {6'b000000, S_SEARCH},
            {6'b011000, S_ROTATE}, {6'b011000, S_ROTATE}, {6'b011000, S_ROTATE},
            {6'b001000, S_FOLLOW},
            {6'b011000, S_ROTATE}, {6'b011000, S_ROTATE},
            {6'b011000, S_ROTATE}, {6'b011000, S_ROTATE},
            {6'b011000, S_STANDBY}});
    endtask

    task automatic test_remove_once();
        do_reset();
        run_table("remove_once", '{
            {6'b000000, S_SEARCH},
            {6'b000001, S_REMOVE}, {6'b000000, S_REMOVE}, {6'b000000, S_REMOVE},
            {6'b000000, S_SEARCH}});
        check_stats("remove_once_stats", 1);
    endtask

    task automatic test_back_to_back();
        run_table("back_to_back", '{
            {6'b000001, S_REMOVE}, {6'b000000, S_REMOVE}, {6'b000000, S_REMOVE},
            {6'b001000, S_FOLLOW},
            {6'b001001, S_REMOVE}, {6'b001000, S_REMOVE}, {6'b001000, S_REMOVE},
            {6'b001000, S_FOLLOW}});
        check_stats("back_to_back_stats", 3);
    endtask

    task automatic test_remove_retry();
        do_reset();
        run_table("remove_retry", '{
            {6'b000000, S_SEARCH},
            {6'b000001, S_REMOVE}, {6'b000001, S_REMOVE}, {6'b000001, S_REMOVE},
            {6'b000001, S_REMOVE}, {6'b000001, S_REMOVE}, {6'b000001, S_REMOVE},
            {6'b000001, S_REMOVE}, {6'b000001, S_REMOVE}, {6'b000001, S_REMOVE},
            {6'b000001, S_STANDBY}});
        check_stats("remove_retry_stats", 0);
    endtask

    task automatic test_under_abort();
        obs_t got, want;
        do_reset();
        run_table("under_abort", '{
            {6'b000000, S_SEARCH},
            {6'b000001, S_REMOVE}, {6'b000001, S_REMOVE},
            {6'b000011, S_STANDBY}});
        sb.push_back(expect_of(S_INIT));
        do_reset();
        got = {estado, avancar, girar, remover}; want = sb.pop_front(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL reset_after_abort: got %b want %b", got, want);
        end
        run_table("under_beats_barrier", '{
            {6'b000000, S_SEARCH}, {6'b000011, S_STANDBY}});
    endtask

    initial begin
        test_reset();
        test_follow_left();
        test_follow_right();
        test_rotate_stuck();
        test_rotate_exit();
        test_remove_once();
        test_back_to_back();
        test_remove_retry();
        test_under_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
